// File: rtl/dcache_block_requester_if.sv
// dcache_block_requester_if: CPU request/response channels plus the cache array bus.
// master = requester/array environment, slave = the block requester controller.
`default_nettype none

interface dcache_block_requester_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W+2:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic [ADDR_W-1:0]     dc_addr;
  logic [DATA_W-1:0]     dc_wdata1;
  logic [DATA_W-1:0]     dc_wdata2;
  logic                  dc_write;
  logic [DATA_W-1:0]     dc_rdata1;
  logic [DATA_W-1:0]     dc_rdata2;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
           dc_rdata1, dc_rdata2,
    input  req_ready, resp_valid, resp_rdata, dc_addr, dc_wdata1, dc_wdata2, dc_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
           dc_rdata1, dc_rdata2,
    output req_ready, resp_valid, resp_rdata, dc_addr, dc_wdata1, dc_wdata2, dc_write
  );
endinterface

`default_nettype wire

// File: rtl/dcache_block_requester.sv
// dcache_block_requester: single-word load/store front end for a two-word-block cache array;
// byte-masked stores are done as read-modify-write of the aligned block.  Rev 1.0
`default_nettype none

module dcache_block_requester #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  dcache_block_requester_if.slave   bus
);
  localparam int         c_NB    = DATA_W / 8;
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_write;
  logic              r_sel;
  logic [DATA_W-1:0] r_wdata;
  logic [c_NB-1:0]   r_wmask;
  logic [ADDR_W-1:0] r_dc_addr;
  logic              r_dc_write;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [DATA_W-1:0] r_dc_wdata1;
  logic [DATA_W-1:0] r_dc_wdata2;

  logic              w_accept;
  logic [ADDR_W-1:0] w_word;
  logic [2:0]        w_unused_addr_lsb;
  logic [c_NB-1:0]   w_eff_mask;
  logic [DATA_W-1:0] w_sel_word;
  logic [DATA_W-1:0] w_merged;
  logic              w_dc_write_nxt;
  logic              w_resp_valid_nxt;
  logic [DATA_W-1:0] w_resp_rdata_nxt;
  logic [DATA_W-1:0] w_dc_wdata1_nxt;
  logic [DATA_W-1:0] w_dc_wdata2_nxt;

  assign w_accept          = bus.req_valid && (r_state == c_IDLE);
  assign w_word            = bus.req_addr[ADDR_W+2:3];
  assign w_unused_addr_lsb = bus.req_addr[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.req_valid) w_state_nxt = c_READ;
      c_READ:  w_state_nxt = r_write ? c_WRITE : c_RESP;
      c_WRITE: w_state_nxt = c_RESP;
      c_RESP:  if (bus.resp_ready) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // A load reuses the merge path with an all-zero mask, so the block buffer
  // always holds exactly what the array returned.
  always_comb begin
    w_eff_mask = r_write ? r_wmask : '0;
    w_sel_word = r_sel ? bus.dc_rdata2 : bus.dc_rdata1;
    w_merged   = w_sel_word;
    for (int i = 0; i < c_NB; i++) begin
      if (w_eff_mask[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_dc_write_nxt   = r_dc_write;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_dc_wdata1_nxt  = r_dc_wdata1;
    w_dc_wdata2_nxt  = r_dc_wdata2;
    case (r_state)
      c_READ: begin
        w_dc_wdata1_nxt = r_sel ? bus.dc_rdata1 : w_merged;
        w_dc_wdata2_nxt = r_sel ? w_merged : bus.dc_rdata2;
        if (r_write) begin
          w_dc_write_nxt = 1'b1;
        end else begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_sel_word;
        end
      end
      c_WRITE: begin
        w_dc_write_nxt   = 1'b0;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = '0;
      end
      c_RESP: if (bus.resp_ready) w_resp_valid_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_sel        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_dc_addr    <= '0;
      r_dc_write   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_dc_wdata1  <= '0;
      r_dc_wdata2  <= '0;
    end else begin
      if (w_accept) begin
        r_write   <= bus.req_write;
        r_sel     <= w_word[0];
        r_wdata   <= bus.req_wdata;
        r_wmask   <= bus.req_wmask;
        r_dc_addr <= {w_word[ADDR_W-1:1], 1'b0};
      end
      r_dc_write   <= w_dc_write_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_dc_wdata1  <= w_dc_wdata1_nxt;
      r_dc_wdata2  <= w_dc_wdata2_nxt;
    end
  end

  assign bus.req_ready  = (r_state == c_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.dc_addr    = r_dc_addr;
  assign bus.dc_write   = r_dc_write;
  assign bus.dc_wdata1  = r_dc_wdata1;
  assign bus.dc_wdata2  = r_dc_wdata2;
endmodule

`default_nettype wire

// File: tb/tb_dcache_block_requester.sv
// tb_dcache_block_requester: directed plus random load/store traffic against a word-level
// memory model; the array itself is a behavioural 2048 x 64 memory driven by the DUT.
`default_nettype none

module tb_dcache_block_requester;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_block_requester_if #(.ADDR_W(11), .DATA_W(64)) bus ();

  dcache_block_requester #(.ADDR_W(11), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem     [0:2047];
  logic [63:0] ref_mem [0:2047];
  logic        pl_we = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [63:0] pl_data = '0;
  int          wr_pulses = 0;
  logic        prev_wr = 1'b0;
  logic        double_pulse = 1'b0;
  logic [10:0] last_addr = '0;
  logic [63:0] last_wd1 = '0, last_wd2 = '0;

  int errors = 0;
  int checks = 0;

  assign bus.dc_rdata1 = mem[bus.dc_addr];
  assign bus.dc_rdata2 = mem[bus.dc_addr + 11'd1];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.dc_write) begin
      mem[bus.dc_addr]         <= bus.dc_wdata1;
      mem[bus.dc_addr + 11'd1] <= bus.dc_wdata2;
      wr_pulses <= wr_pulses + 1;
      last_addr <= bus.dc_addr;
      last_wd1  <= bus.dc_wdata1;
      last_wd2  <= bus.dc_wdata2;
      if (prev_wr) double_pulse <= 1'b1;
    end
    prev_wr <= bus.dc_write;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [63:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // One request/response; the model updates ref_mem at word level, independent of block pairing.
  task automatic xact(input bit wr, input logic [13:0] addr, input logic [63:0] wd,
                      input logic [7:0] m, input int hold, output logic [63:0] rdata);
    logic [10:0] w;
    logic [10:0] base;
    logic [63:0] exp_rd;
    int n, edges, p0;
    w = addr[13:3];
    base = {w[10:1], 1'b0};
    if (wr) begin
      for (int b = 0; b < 8; b++) if (m[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      exp_rd = '0;
    end else begin
      exp_rd = ref_mem[w];
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_wmask = m; bus.resp_ready = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", 64'(n < 20), 64'd1);
    p0 = wr_pulses;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("dc_addr", 64'(bus.dc_addr), 64'(base));
    edges = 1;
    while (!bus.resp_valid && edges < 20) begin @(negedge clk); edges++; end
    check(wr ? "store_latency" : "load_latency", 64'(edges), wr ? 64'd3 : 64'd2);
    check("resp_rdata", bus.resp_rdata, exp_rd);
    rdata = bus.resp_rdata;
    check("write_pulses", 64'(wr_pulses - p0), 64'(wr));
    check("single_pulse", 64'(double_pulse), 64'd0);
    if (wr) begin
      check("wr_addr", 64'(last_addr), 64'(base));
      check("wdata1", last_wd1, ref_mem[base]);
      check("wdata2", last_wd2, ref_mem[base + 11'd1]);
    end
    if (hold > 0) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 14'h0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(bus.resp_valid), 64'd1);
        check("hold_rdata", bus.resp_rdata, exp_rd);
        check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("resp_done", 64'(bus.resp_valid), 64'd0);
    check("ready_after", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    int p0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_dc_write", 64'(bus.dc_write), 64'd0);
    check("rst_dc_addr", 64'(bus.dc_addr), 64'd0);
    check("rst_dc_wdata1", bus.dc_wdata1, 64'd0);
    check("rst_dc_wdata2", bus.dc_wdata2, 64'd0);

    preload(11'd2, 64'hAAAA);
    preload(11'd3, 64'h1234);
    xact(1'b0, 14'h18, 64'h0, 8'h00, 0, rd);
    check("load_w3", rd, 64'h1234);

    preload(11'd2, 64'h0);
    preload(11'd3, 64'h55);
    xact(1'b1, 14'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, rd);
    check("store_w2_wd1", last_wd1, 64'h0000_0000_FFFF_FFFF);
    check("store_w2_wd2", last_wd2, 64'h55);

    preload(11'd2046, 64'hDEAD_BEEF_0123_4567);
    preload(11'd2047, 64'hCAFE_F00D_89AB_CDEF);
    xact(1'b1, 14'h3FF8, 64'h1111_1111_1111_1111, 8'h00, 0, rd);
    check("top_wd1", last_wd1, 64'hDEAD_BEEF_0123_4567);
    check("top_wd2", last_wd2, 64'hCAFE_F00D_89AB_CDEF);

    xact(1'b0, 14'h18, 64'h0, 8'h00, 5, rd);

    preload(11'd5, 64'h1111_2222_3333_4444);
    xact(1'b1, 14'h28, 64'h42, 8'h01, 0, rd);
    xact(1'b0, 14'h28, 64'h0, 8'h00, 0, rd);
    check("b2b_load", rd, 64'h1111_2222_3333_4442);

    // Reset lands in READ of a store: nothing may reach the array.
    preload(11'd6, 64'h0BAD_CAFE_0000_0006);
    preload(11'd7, 64'h7777);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 14'h30;
    bus.req_wdata = '1; bus.req_wmask = 8'hFF;
    p0 = wr_pulses;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_dc_write", 64'(bus.dc_write), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mid_resp", 64'(bus.resp_valid), 64'd0);
    check("rst_mid_pulses", 64'(wr_pulses - p0), 64'd0);
    xact(1'b0, 14'h30, 64'h0, 8'h00, 0, rd);
    check("rst_mid_data", rd, 64'h0BAD_CAFE_0000_0006);

    for (int a = 0; a < 16; a++) preload(11'(a), {$urandom, $urandom});
    for (int k = 0; k < 40; k++) begin
      logic [7:0] m;
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      xact(1'($urandom), {$urandom_range(0, 15) == 0 ? 4'd0 : 4'($urandom_range(0, 15)), 3'($urandom)} == 0
             ? 14'h0 : {7'd0, 4'($urandom_range(0, 15)), 3'($urandom)},
           {$urandom, $urandom}, m, $urandom_range(0, 2), rd);
    end
    for (int a = 0; a < 16; a++) check("final_mem", mem[a], ref_mem[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
